// File: rtl/irq_trap_controller.sv
// rtl/irq_trap_controller.sv - IRQ synchronizer, trap arbiter and WFI sequencer
module irq_trap_controller #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        irq_msip_async,
   input  logic        irq_mtip_async,
   input  logic        irq_meip_async,
   output logic        irq_msip,
   output logic        irq_mtip,
   output logic        irq_meip,
   input  logic [31:0] mie,
   input  logic        mstatus_mie,
   input  logic [1:0]  privilege_mode,
   input  logic        inst_boundary,
   input  logic [31:0] pc,
   input  logic        exc_instr_misalign,
   input  logic        exc_illegal,
   input  logic        exc_ecall,
   input  logic        exc_ebreak,
   input  logic        exc_load_misalign,
   input  logic        exc_store_misalign,
   input  logic [31:0] exc_tval,
   input  logic        wfi_req,
   output logic        exception_event,
   output logic [31:0] cause,
   output logic [31:0] badaddr,
   output logic [31:0] trap_pc,
   output logic        redirect_req,
   input  logic        redirect_ack,
   output logic        trap_busy,
   output logic        wfi_stall
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_FIRE     = 2'd1;
   localparam logic [1:0] ST_REDIRECT = 2'd2;
   localparam logic [1:0] ST_WFI      = 2'd3;

   logic [SYNC_STAGES-1:0] r_sync_msip;
   logic [SYNC_STAGES-1:0] r_sync_mtip;
   logic [SYNC_STAGES-1:0] r_sync_meip;
   logic [1:0]             r_state;
   logic [31:0]            r_cause;
   logic [31:0]            r_badaddr;
   logic [31:0]            r_trap_pc;

   logic [2:0]  w_pend;
   logic        w_irq_en;
   logic        w_any_exc;
   logic        w_take_irq;
   logic [31:0] w_exc_cause;
   logic [31:0] w_exc_badaddr;
   logic [31:0] w_irq_cause;
   logic        w_unused;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_sync_msip <= '0;
         r_sync_mtip <= '0;
         r_sync_meip <= '0;
      end else begin
         r_sync_msip <= {r_sync_msip[SYNC_STAGES-2:0], irq_msip_async};
         r_sync_mtip <= {r_sync_mtip[SYNC_STAGES-2:0], irq_mtip_async};
         r_sync_meip <= {r_sync_meip[SYNC_STAGES-2:0], irq_meip_async};
      end
   end

   assign irq_msip = r_sync_msip[SYNC_STAGES-1];
   assign irq_mtip = r_sync_mtip[SYNC_STAGES-1];
   assign irq_meip = r_sync_meip[SYNC_STAGES-1];

   assign w_pend     = {irq_meip & mie[11], irq_mtip & mie[7], irq_msip & mie[3]};
   assign w_irq_en   = (privilege_mode != 2'b11) | mstatus_mie;
   assign w_any_exc  = exc_instr_misalign | exc_illegal | exc_ecall | exc_ebreak
                     | exc_load_misalign | exc_store_misalign;
   assign w_take_irq = inst_boundary & w_irq_en & (|w_pend);
   assign w_unused   = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};

   always_comb begin
      w_exc_cause   = 32'd6;
      w_exc_badaddr = exc_tval;
      if (exc_instr_misalign) begin
         w_exc_cause = 32'd0;
      end else if (exc_illegal) begin
         w_exc_cause = 32'd2;
      end else if (exc_ecall) begin
         // ecall cause encodes the originating privilege: 8 (U) .. 11 (M)
         w_exc_cause   = 32'd8 + {30'd0, privilege_mode};
         w_exc_badaddr = 32'd0;
      end else if (exc_ebreak) begin
         w_exc_cause   = 32'd3;
         w_exc_badaddr = pc;
      end else if (exc_load_misalign) begin
         w_exc_cause = 32'd4;
      end
   end

   always_comb begin
      w_irq_cause = 32'h8000_0007;
      if (w_pend[2]) begin
         w_irq_cause = 32'h8000_000B;
      end else if (w_pend[0]) begin
         w_irq_cause = 32'h8000_0003;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_cause   <= 32'd0;
         r_badaddr <= 32'd0;
         r_trap_pc <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_exc) begin
                  r_state   <= ST_FIRE;
                  r_cause   <= w_exc_cause;
                  r_badaddr <= w_exc_badaddr;
                  r_trap_pc <= pc;
               end else if (w_take_irq) begin
                  r_state   <= ST_FIRE;
                  r_cause   <= w_irq_cause;
                  r_badaddr <= 32'd0;
                  r_trap_pc <= pc;
               end else if (wfi_req) begin
                  r_state <= ST_WFI;
               end
            end
            ST_FIRE: r_state <= ST_REDIRECT;
            ST_REDIRECT: begin
               if (redirect_ack) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_WFI: begin
               // wake ignores irq_en; the trap itself is gated at the next boundary
               if (|w_pend) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign exception_event = (r_state == ST_FIRE);
   assign redirect_req    = (r_state == ST_REDIRECT);
   assign wfi_stall       = (r_state == ST_WFI);
   assign trap_busy       = (r_state != ST_IDLE);
   assign cause           = r_cause;
   assign badaddr         = r_badaddr;
   assign trap_pc         = r_trap_pc;

endmodule

// File: tb/tb_irq_trap_controller.sv
// tb/tb_irq_trap_controller.sv - self-checking bench for irq_trap_controller
module tb_irq_trap_controller;
   localparam int S = 3;

   logic        clk = 1'b0;
   logic        resetn;
   logic        irq_msip_async, irq_mtip_async, irq_meip_async;
   logic        irq_msip, irq_mtip, irq_meip;
   logic [31:0] mie;
   logic        mstatus_mie;
   logic [1:0]  privilege_mode;
   logic        inst_boundary;
   logic [31:0] pc;
   logic        exc_instr_misalign, exc_illegal, exc_ecall, exc_ebreak;
   logic        exc_load_misalign, exc_store_misalign;
   logic [31:0] exc_tval;
   logic        wfi_req;
   logic        exception_event;
   logic [31:0] cause, badaddr, trap_pc;
   logic        redirect_req, redirect_ack, trap_busy, wfi_stall;

   int checks = 0;
   int errors = 0;
   int n;

   irq_trap_controller #(.SYNC_STAGES(S)) dut (
      .clk(clk), .resetn(resetn),
      .irq_msip_async(irq_msip_async), .irq_mtip_async(irq_mtip_async),
      .irq_meip_async(irq_meip_async),
      .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
      .mie(mie), .mstatus_mie(mstatus_mie), .privilege_mode(privilege_mode),
      .inst_boundary(inst_boundary), .pc(pc),
      .exc_instr_misalign(exc_instr_misalign), .exc_illegal(exc_illegal),
      .exc_ecall(exc_ecall), .exc_ebreak(exc_ebreak),
      .exc_load_misalign(exc_load_misalign), .exc_store_misalign(exc_store_misalign),
      .exc_tval(exc_tval), .wfi_req(wfi_req),
      .exception_event(exception_event), .cause(cause), .badaddr(badaddr),
      .trap_pc(trap_pc), .redirect_req(redirect_req), .redirect_ack(redirect_ack),
      .trap_busy(trap_busy), .wfi_stall(wfi_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: sampled-history queues for the synchronizers and a
   // trap phase (0 idle, 1 strobe, 2 awaiting ack, 3 sleeping).
   bit          h_msip[$], h_mtip[$], h_meip[$];
   bit          m_valid = 0;
   int          m_phase;
   logic [31:0] m_cause, m_bad, m_pc;

   function automatic bit pick_exc(output logic [31:0] c, output logic [31:0] b);
      bit req [6];
      int codes [6];
      req   = '{exc_instr_misalign, exc_illegal, exc_ecall, exc_ebreak,
                exc_load_misalign, exc_store_misalign};
      codes = '{0, 2, 8, 3, 4, 6};
      c = 0;
      b = 0;
      for (int i = 0; i < 6; i++) begin
         if (req[i]) begin
            c = codes[i] + ((i == 2) ? int'(privilege_mode) : 0);
            b = (i == 2) ? 32'd0 : (i == 3) ? pc : exc_tval;
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      if (!resetn) begin
         m_valid = 1;
         m_phase = 0;
         m_cause = 0; m_bad = 0; m_pc = 0;
         h_msip.delete(); h_mtip.delete(); h_meip.delete();
         for (int i = 0; i < S; i++) begin
            h_msip.push_back(0); h_mtip.push_back(0); h_meip.push_back(0);
         end
      end else if (m_valid) begin
         bit          p_mei, p_msi, p_mti, en;
         logic [31:0] c, b;
         p_mei = h_meip[S-1] & mie[11];
         p_msi = h_msip[S-1] & mie[3];
         p_mti = h_mtip[S-1] & mie[7];
         en    = (privilege_mode != 2'd3) || mstatus_mie;
         case (m_phase)
            0: begin
               if (pick_exc(c, b)) begin
                  m_phase = 1; m_cause = c; m_bad = b; m_pc = pc;
               end else if (inst_boundary && en && (p_mei || p_msi || p_mti)) begin
                  m_phase = 1;
                  m_cause = p_mei ? 32'h8000_000B : p_msi ? 32'h8000_0003 : 32'h8000_0007;
                  m_bad = 0; m_pc = pc;
               end else if (wfi_req) begin
                  m_phase = 3;
               end
            end
            1: m_phase = 2;
            2: if (redirect_ack) m_phase = 0;
            default: if (p_mei || p_msi || p_mti) m_phase = 0;
         endcase
         h_msip.push_front(irq_msip_async); void'(h_msip.pop_back());
         h_mtip.push_front(irq_mtip_async); void'(h_mtip.pop_back());
         h_meip.push_front(irq_meip_async); void'(h_meip.pop_back());
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cmp_irq_msip", {31'd0, irq_msip}, {31'd0, h_msip[S-1]});
         chk("cmp_irq_mtip", {31'd0, irq_mtip}, {31'd0, h_mtip[S-1]});
         chk("cmp_irq_meip", {31'd0, irq_meip}, {31'd0, h_meip[S-1]});
         chk("cmp_event", {31'd0, exception_event}, {31'd0, m_phase == 1});
         chk("cmp_redirect", {31'd0, redirect_req}, {31'd0, m_phase == 2});
         chk("cmp_wfi_stall", {31'd0, wfi_stall}, {31'd0, m_phase == 3});
         chk("cmp_busy", {31'd0, trap_busy}, {31'd0, m_phase != 0});
         chk("cmp_cause", cause, m_cause);
         chk("cmp_badaddr", badaddr, m_bad);
         chk("cmp_trap_pc", trap_pc, m_pc);
      end
   end

   // Waits for the strobe, checks it literally, then completes the redirect handshake.
   task automatic run_trap(input string name, input logic [31:0] ec, input logic [31:0] eb,
                           input logic [31:0] ep, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!exception_event && lat < 40);
      chk({name, "_event"}, {31'd0, exception_event}, 32'd1);
      chk({name, "_cause"}, cause, ec);
      chk({name, "_badaddr"}, badaddr, eb);
      chk({name, "_trap_pc"}, trap_pc, ep);
      {exc_instr_misalign, exc_illegal, exc_ecall, exc_ebreak,
       exc_load_misalign, exc_store_misalign} = '0;
      inst_boundary = 0;
      @(negedge clk);
      chk({name, "_event_one_cycle"}, {31'd0, exception_event}, 32'd0);
      chk({name, "_redirect_req"}, {31'd0, redirect_req}, 32'd1);
      redirect_ack = 1;
      @(negedge clk);
      redirect_ack = 0;
      chk({name, "_redirect_drop"}, {31'd0, redirect_req}, 32'd0);
      chk({name, "_idle"}, {31'd0, trap_busy}, 32'd0);
   endtask

   initial begin
      resetn = 0;
      {irq_msip_async, irq_mtip_async, irq_meip_async} = '0;
      mie = 0; mstatus_mie = 0; privilege_mode = 2'd3; inst_boundary = 0;
      pc = 0; exc_tval = 0; wfi_req = 0; redirect_ack = 0;
      {exc_instr_misalign, exc_illegal, exc_ecall, exc_ebreak,
       exc_load_misalign, exc_store_misalign} = '0;
      repeat (3) @(negedge clk);
      chk("reset_cause", cause, 32'd0);
      chk("reset_busy", {31'd0, trap_busy}, 32'd0);
      chk("reset_irq_meip", {31'd0, irq_meip}, 32'd0);
      resetn = 1;

      exc_illegal = 1; exc_tval = 32'hDEADBEEF; pc = 32'h8000_0100;
      run_trap("illegal", 32'd2, 32'hDEADBEEF, 32'h8000_0100, n);
      chk("illegal_latency", n, 32'd1);

      privilege_mode = 2'd0; exc_ecall = 1; exc_tval = 32'h55; pc = 32'h100;
      run_trap("ecall_u", 32'd8, 32'd0, 32'h100, n);
      privilege_mode = 2'd3; exc_ecall = 1; pc = 32'h104;
      run_trap("ecall_m", 32'd11, 32'd0, 32'h104, n);
      privilege_mode = 2'd0; exc_ecall = 1; exc_load_misalign = 1; pc = 32'h108;
      run_trap("ecall_over_load", 32'd8, 32'd0, 32'h108, n);
      exc_ebreak = 1; exc_store_misalign = 1; exc_tval = 32'h77; pc = 32'h2000;
      run_trap("ebreak_over_store", 32'd3, 32'h2000, 32'h2000, n);
      exc_store_misalign = 1; exc_tval = 32'h2002; pc = 32'h2004;
      run_trap("store_misalign", 32'd6, 32'h2002, 32'h2004, n);
      exc_instr_misalign = 1; exc_illegal = 1; exc_tval = 32'h1234_5679; pc = 32'h10;
      run_trap("misalign_over_illegal", 32'd0, 32'h1234_5679, 32'h10, n);

      privilege_mode = 2'd3; mstatus_mie = 1; mie = 32'h888; pc = 32'h300;
      inst_boundary = 1;
      {irq_msip_async, irq_mtip_async, irq_meip_async} = 3'b111;
      run_trap("irq_mei", 32'h8000_000B, 32'd0, 32'h300, n);
      chk("irq_sync_latency", n, S + 1);
      irq_meip_async = 0;
      repeat (S + 2) @(negedge clk);
      inst_boundary = 1;
      run_trap("irq_msi", 32'h8000_0003, 32'd0, 32'h300, n);
      irq_msip_async = 0;
      repeat (S + 2) @(negedge clk);
      inst_boundary = 1;
      run_trap("irq_mti", 32'h8000_0007, 32'd0, 32'h300, n);
      irq_mtip_async = 0;
      repeat (S + 2) @(negedge clk);

      mstatus_mie = 0; irq_mtip_async = 1; inst_boundary = 1; pc = 32'h340;
      repeat (S + 6) @(negedge clk);
      chk("gate_no_trap", {31'd0, trap_busy}, 32'd0);
      privilege_mode = 2'd0;
      run_trap("gate_umode", 32'h8000_0007, 32'd0, 32'h340, n);
      irq_mtip_async = 0; privilege_mode = 2'd3; mstatus_mie = 1;
      repeat (S + 2) @(negedge clk);

      irq_mtip_async = 1;
      repeat (S + 2) @(negedge clk);
      inst_boundary = 1; exc_load_misalign = 1; exc_tval = 32'h1003; pc = 32'h400;
      run_trap("exc_beats_irq", 32'd4, 32'h1003, 32'h400, n);
      inst_boundary = 1;
      run_trap("irq_after_exc", 32'h8000_0007, 32'd0, 32'h400, n);
      irq_mtip_async = 0;
      repeat (S + 2) @(negedge clk);

      mstatus_mie = 0; wfi_req = 1;
      @(negedge clk);
      wfi_req = 0;
      chk("wfi_stall_on", {31'd0, wfi_stall}, 32'd1);
      irq_msip_async = 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (wfi_stall && n < 40);
      chk("wfi_wake_latency", n, S + 1);
      inst_boundary = 1;
      repeat (5) @(negedge clk);
      chk("wfi_no_trap", {31'd0, trap_busy}, 32'd0);
      inst_boundary = 0; irq_msip_async = 0;
      repeat (S + 2) @(negedge clk);

      wfi_req = 1;
      @(negedge clk);
      wfi_req = 0;
      chk("wfi2_stall_on", {31'd0, wfi_stall}, 32'd1);
      resetn = 0;
      @(negedge clk);
      chk("wfi_reset_stall", {31'd0, wfi_stall}, 32'd0);
      chk("wfi_reset_busy", {31'd0, trap_busy}, 32'd0);
      resetn = 1;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/irq_trap_controller.md
# irq_trap_controller

Trap sequencer sitting between the multicycle control unit and `csr_exception_handler`. It synchronizes the external interrupt lines and arbitrates pending interrupts against synchronous exceptions. It drives the single-cycle `exception_event` / `cause` / `badaddr` / `pc` strobe into the CSR block, then handshakes the PC redirect back to the control unit. It also implements the WFI stall.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops per IRQ synchronizer; legal values are ≥2.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `irq_msip_async`, `irq_mtip_async`, `irq_meip_async` in 1 each: asynchronous interrupt lines.
- `irq_msip`, `irq_mtip`, `irq_meip` out 1 each: synchronized lines. They feed the CSR `IRQ3`/`IRQ7` inputs and the MEIP input.
- `mie` in 32: CSR `mie`. Bits 3, 7 and 11 are used.
- `mstatus_mie` in 1: `mstatus.MIE`.
- `privilege_mode` in 2: current privilege.
- `inst_boundary` in 1: control unit is at fetch. An interrupt may be taken here.
- `pc` in 32: PC of the current instruction. At a boundary, this is the next instruction to execute.
- `exc_instr_misalign`, `exc_illegal`, `exc_ecall`, `exc_ebreak`, `exc_load_misalign`, `exc_store_misalign` in 1 each: synchronous exception requests.
- `exc_tval` in 32: faulting address or instruction word.
- `wfi_req` in 1: a WFI instruction is executing (1-cycle pulse).
- `exception_event` out 1: 1-cycle strobe to the CSR block.
- `cause` out 32: mcause value.
- `badaddr` out 32: mtval value.
- `trap_pc` out 32: mepc value.
- `redirect_req` out 1: control unit must load `exception_next_pc`.
- `redirect_ack` in 1: control unit has loaded `exception_next_pc`.
- `trap_busy` out 1: asserted when the state is not IDLE.
- `wfi_stall` out 1: control unit holds in place.

## Operation
States: IDLE, FIRE, REDIRECT, WFI.

**Synchronizers**
- Each IRQ line passes through `SYNC_STAGES` flops.
- `pend = {meip, mtip, msip}` synchronized, ANDed with `mie[11]`, `mie[7]`, `mie[3]`.
- `irq_en = (privilege_mode != M) | mstatus_mie`.

**IDLE transitions** (evaluated every cycle)
- Any exc_* input is high → latch the highest-priority exception, go to FIRE.
  - Priority: instr_misalign (cause 0, badaddr = `exc_tval`) > illegal (2, `exc_tval`) > ecall (8 + `privilege_mode`, i.e. 8 or 11; badaddr 0) > ebreak (3, `pc`) > load_misalign (4, `exc_tval`) > store_misalign (6, `exc_tval`).
- Otherwise, if `inst_boundary & irq_en & |pend` → latch the interrupt, go to FIRE.
  - Priority: MEI 0x8000000B > MSI 0x80000003 > MTI 0x80000007.
  - badaddr = 0.
- Otherwise, if `wfi_req` → go to WFI.
- `trap_pc` latches `pc` in the same cycle as the cause.
- An exception in the same cycle as a pending interrupt: the exception wins. The interrupt stays pending and is re-evaluated at the next boundary.

**FIRE**
- `exception_event = 1` for exactly one cycle.
- `cause`, `badaddr` and `trap_pc` are stable.
- Unconditionally go to REDIRECT.

**REDIRECT**
- `redirect_req = 1`, held until `redirect_ack` is sampled high, then go to IDLE.
- `redirect_ack` while not in REDIRECT is ignored.

**WFI**
- `wfi_stall = 1`.
- Exit to IDLE when `|pend` is true, independent of `irq_en` (privileged-spec wake rule).
- If `irq_en` is set, the interrupt is taken at the next `inst_boundary`.

**Busy behaviour**
- exc_* and `wfi_req` inputs are ignored outside IDLE; the control unit is stalled by `trap_busy`.
- `cause`, `badaddr` and `trap_pc` hold their values until the next latch.

## Timing
Reset values:
- State IDLE.
- All synchronizer flops 0.
- `exception_event`, `redirect_req`, `wfi_stall` and `trap_busy` are 0.
- `cause`, `badaddr` and `trap_pc` are 0.

Reset mid-operation (any state) returns to IDLE on the next edge, with no strobe emitted.

Latencies:
- Async IRQ edge → `irq_*` high: `SYNC_STAGES` cycles.
- Request sampled in IDLE at edge N → FIRE in cycle N+1 (`exception_event` high). The CSR registers update at edge N+2.
- REDIRECT in cycle N+2. The CSR `exception_select` / `exception_next_pc` are valid in this cycle.
- Earliest return to IDLE is cycle N+3, when `redirect_ack` is high in cycle N+2.
- WFI exit: 1 cycle after `|pend` is visible.

`exception_event` is registered (a state decode of FIRE). It never stays high for two consecutive cycles.

## Test plan
- **Illegal instruction:** `exc_illegal = 1`, `exc_tval = 0xDEADBEEF`, `pc = 0x80000100` → one-cycle `exception_event` with cause 2, badaddr 0xDEADBEEF, trap_pc 0x80000100. `redirect_req` is high the next cycle and drops the cycle after `redirect_ack`.
- **Ecall from U-mode:** `privilege_mode = 0` → cause 8. From M-mode → cause 11. badaddr is 0 in both cases.
- **Interrupt priority:** all three IRQs asserted, `mie = 0x888`, `mstatus_mie = 1`, `inst_boundary = 1` → cause 0x8000000B. After MEI is dropped → 0x80000003. After MSI is also dropped → 0x80000007. The first cause appears no earlier than `SYNC_STAGES + 1` cycles after the IRQ edge.
- **Gating:** M-mode with `mstatus_mie = 0` and pending MTI → no trap. Switching to U-mode → trap taken at the next boundary.
- **Exception vs interrupt in the same cycle:** `exc_load_misalign` together with pending enabled MTI → cause 4 first. At the next boundary after the redirect → cause 0x80000007.
- **WFI:** `wfi_req` with `mstatus_mie = 0`, then MSI pending with `mie[3] = 1` → `wfi_stall` drops; no trap is taken.
- **WFI reset:** `resetn` low during WFI → `wfi_stall` is 0 the next cycle and the state is IDLE.
